// File: rtl/mux_sel_pkg.sv
// Shared types and constants for the keyed-mux select sequencer.
// Latency: n/a (package only).
// Backpressure: n/a.
package mux_sel_pkg;

    localparam int SEL_W  = 2;
    localparam int NR_SEL = 4;

    typedef enum logic {
        STABLE = 1'b0,
        CHECK  = 1'b1
    } deb_state_e;

    // Step a select value one position forward or backward, wrapping modulo NR_SEL.
    function automatic logic [SEL_W-1:0] sel_step(input logic [SEL_W-1:0] cur, input logic fwd);
        int nxt;
        if (fwd) begin
            nxt = (int'(cur) + 1) % NR_SEL;
        end else begin
            nxt = (int'(cur) + NR_SEL - 1) % NR_SEL;
        end
        return SEL_W'(nxt);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-flop synchronizer followed by a STABLE/CHECK debounce FSM.
// Latency: level flips DEB_CYCLES+2 edges after the raw input changes; rise pulses on that edge.
// Backpressure: none; free-running, one sample per clock.
module btn_debounce
    import mux_sel_pkg::*;
#(
    parameter int DEB_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic lvl,
    output logic rise
);

    localparam int CNT_W = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic [1:0]       sync_q, sync_d;
    deb_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             lvl_q, lvl_d;
    logic             diff;

    // Synchronizer shift and debounce next-state; rise fires on the edge the level goes high.
    always_comb begin
        sync_d  = {sync_q[0], btn_raw};
        state_d = state_q;
        cnt_d   = cnt_q;
        lvl_d   = lvl_q;
        rise    = 1'b0;
        diff    = sync_q[1] ^ lvl_q;
        case (state_q)
            STABLE: begin
                cnt_d = '0;
                if (diff) begin
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (!diff) begin
                    state_d = STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    lvl_d   = ~lvl_q;
                    rise    = ~lvl_q;
                    state_d = STABLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = STABLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State registers; reset discards any press in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= 2'b00;
            state_q <= STABLE;
            cnt_q   <= '0;
            lvl_q   <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lvl_q   <= lvl_d;
        end
    end

    assign lvl = lvl_q;

endmodule

// File: rtl/mux_sel_seq.sv
// Select sequencer for a 4-way keyed mux: debounced next/prev buttons step s; optional auto-scan
// (build macro MUX_SEL_SEQ_AUTOSCAN_EN). Latency: s and sel_chg update DEB_CYCLES+2 edges after a press.
// Backpressure: none; s is always valid, sel_chg pulses for one cycle per change.
module mux_sel_seq
    import mux_sel_pkg::*;
#(
    parameter int DEB_CYCLES = 16,
    parameter int SCAN_DIV   = 1000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             btn_next,
    input  logic             btn_prev,
    input  logic             mode,
    output logic [SEL_W-1:0] s,
    output logic             sel_chg
);

    logic             next_lvl, next_rise;
    logic             prev_lvl, prev_rise;
    logic [SEL_W-1:0] s_q, s_d;
    logic             sel_chg_q, sel_chg_d;
    logic             manual_en;
    logic             unused_lvl;

    assign unused_lvl = next_lvl ^ prev_lvl;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_next (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_raw (btn_next),
        .lvl     (next_lvl),
        .rise    (next_rise)
    );

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_prev (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_raw (btn_prev),
        .lvl     (prev_lvl),
        .rise    (prev_rise)
    );

`ifdef MUX_SEL_SEQ_AUTOSCAN_EN
    localparam int SCAN_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

    logic              mode_q, mode_d;
    logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
    logic              scan_step;

    // Scan timer restarts on every mode change so the first auto step lands SCAN_DIV cycles later.
    always_comb begin
        mode_d     = mode;
        scan_cnt_d = scan_cnt_q;
        scan_step  = 1'b0;
        if (mode != mode_q) begin
            scan_cnt_d = '0;
        end else if (mode) begin
            if (scan_cnt_q == SCAN_LAST) begin
                scan_cnt_d = '0;
                scan_step  = 1'b1;
            end else begin
                scan_cnt_d = scan_cnt_q + SCAN_W'(1);
            end
        end else begin
            scan_cnt_d = '0;
        end
    end

    // Scan timer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q     <= 1'b0;
            scan_cnt_q <= '0;
        end else begin
            mode_q     <= mode_d;
            scan_cnt_q <= scan_cnt_d;
        end
    end

    assign manual_en = ~mode;
`else
    logic unused_mode;
    logic scan_step;

    assign unused_mode = mode;
    assign scan_step   = 1'b0;
    assign manual_en   = 1'b1;
`endif

    // Select update: simultaneous next/prev rises cancel; auto-scan always steps forward.
    always_comb begin
        s_d       = s_q;
        sel_chg_d = 1'b0;
        if (scan_step) begin
            s_d       = sel_step(s_q, 1'b1);
            sel_chg_d = 1'b1;
        end else if (manual_en && next_rise && !prev_rise) begin
            s_d       = sel_step(s_q, 1'b1);
            sel_chg_d = 1'b1;
        end else if (manual_en && prev_rise && !next_rise) begin
            s_d       = sel_step(s_q, 1'b0);
            sel_chg_d = 1'b1;
        end
    end

    // Output registers drive the downstream mux directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q       <= '0;
            sel_chg_q <= 1'b0;
        end else begin
            s_q       <= s_d;
            sel_chg_q <= sel_chg_d;
        end
    end

    assign s       = s_q;
    assign sel_chg = sel_chg_q;

endmodule

// File: tb/tb_mux_sel_seq.sv
// Bench for mux_sel_seq: directed scenarios plus random button/mode activity against a reference model.
module tb_mux_sel_seq;

    localparam int DEB  = 4;
    localparam int SCAN = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_next = 1'b0;
    logic       btn_prev = 1'b0;
    logic       mode = 1'b0;
    logic [1:0] s;
    logic       sel_chg;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;
    int pulses  = 0;

    // Reference model state: raw history per button, consecutive-difference run, debounced level.
    int m_h1[2];
    int m_h2[2];
    int m_run[2];
    int m_lvl[2];
    int m_s;
    int m_chg;
    int m_mode_q;
    int m_since;

    mux_sel_seq #(.DEB_CYCLES(DEB), .SCAN_DIV(SCAN)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_next (btn_next),
        .btn_prev (btn_prev),
        .mode     (mode),
        .s        (s),
        .sel_chg  (sel_chg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    endtask

    task automatic model_reset();
        for (int b = 0; b < 2; b++) begin
            m_h1[b] = 0; m_h2[b] = 0; m_run[b] = 0; m_lvl[b] = 0;
        end
        m_s = 0; m_chg = 0; m_mode_q = 0; m_since = 0;
    endtask

    // One clock edge of the model: a level flips once the synchronized input has disagreed
    // with it for DEB+1 consecutive samples (entry sample + DEB counted samples).
    task automatic model_edge(input int rn, input int rp, input int md);
        int raw[2];
        int rise[2];
        int manual;
        raw[0] = rn; raw[1] = rp;
        for (int b = 0; b < 2; b++) begin
            int samp;
            samp = m_h2[b];
            m_h2[b] = m_h1[b];
            m_h1[b] = raw[b];
            rise[b] = 0;
            if (samp != m_lvl[b]) m_run[b]++;
            else m_run[b] = 0;
            if (m_run[b] == DEB + 1) begin
                m_lvl[b] = 1 - m_lvl[b];
                m_run[b] = 0;
                rise[b] = m_lvl[b];
            end
        end
        m_chg = 0;
        manual = 1;
`ifdef MUX_SEL_SEQ_AUTOSCAN_EN
        manual = (md == 0);
        if (md != m_mode_q) begin
            m_mode_q = md;
            m_since = 0;
        end else if (md == 1) begin
            m_since++;
            if (m_since == SCAN) begin
                m_since = 0;
                m_s = (m_s + 1) % 4;
                m_chg = 1;
            end
        end
`endif
        if (m_chg == 0 && manual == 1) begin
            if (rise[0] == 1 && rise[1] == 0) begin
                m_s = (m_s + 1) % 4; m_chg = 1;
            end else if (rise[1] == 1 && rise[0] == 0) begin
                m_s = (m_s + 3) % 4; m_chg = 1;
            end
        end
    endtask

    task automatic tick(input logic n, input logic p, input logic md);
        btn_next = n; btn_prev = p; mode = md;
        @(posedge clk);
        cyc++;
        model_edge(int'(n), int'(p), int'(md));
        #1;
        chk("model_s", int'(s), m_s);
        chk("model_sel_chg", int'(sel_chg), m_chg);
        if (sel_chg === 1'b1) pulses++;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("reset_s", int'(s), 0);
        chk("reset_sel_chg", int'(sel_chg), 0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
    endtask

    task automatic press(input logic n, input logic p, input int hi, input int lo);
        for (int i = 0; i < hi; i++) tick(n, p, 1'b0);
        for (int i = 0; i < lo; i++) tick(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic rn, rp, rm;

        // Reset state and single held press: step at edge 10+DEB+2, no repeat while held.
        @(negedge clk);
        do_reset();
        for (int i = 1; i <= 9; i++) tick(1'b0, 1'b0, 1'b0);
        pulses = 0;
        while (cyc < 30) begin
            tick(1'b1, 1'b0, 1'b0);
            if (cyc == 15) chk("held_pre_s", int'(s), 0);
            if (cyc == 16) begin
                chk("held_step_s", int'(s), 1);
                chk("held_step_pulse", int'(sel_chg), 1);
            end
        end
        chk("held_no_repeat_s", int'(s), 1);
        chk("held_one_pulse", pulses, 1);
        press(1'b0, 1'b0, 0, 10);

        // Short glitch is filtered.
        @(negedge clk);
        do_reset();
        pulses = 0;
        press(1'b1, 1'b0, 3, 15);
        chk("glitch_s", int'(s), 0);
        chk("glitch_no_pulse", pulses, 0);

        // Four next presses wrap 3->0, then prev wraps 0->3.
        press(1'b1, 1'b0, 8, 8); chk("next1", int'(s), 1);
        press(1'b1, 1'b0, 8, 8); chk("next2", int'(s), 2);
        press(1'b1, 1'b0, 8, 8); chk("next3", int'(s), 3);
        press(1'b1, 1'b0, 8, 8); chk("next4_wrap", int'(s), 0);
        press(1'b0, 1'b1, 8, 8); chk("prev_wrap", int'(s), 3);

        // Simultaneous rises cancel.
        pulses = 0;
        press(1'b1, 1'b1, 14, 10);
        chk("both_s", int'(s), 3);
        chk("both_no_pulse", pulses, 0);

        // Random button (and, with auto-scan built in, mode) activity.
        rn = 1'b0; rp = 1'b0; rm = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(5) == 0) rn = ~rn;
            if ($urandom_range(5) == 0) rp = ~rp;
`ifdef MUX_SEL_SEQ_AUTOSCAN_EN
            if ($urandom_range(39) == 0) rm = ~rm;
`endif
            tick(rn, rp, rm);
        end
        press(1'b0, 1'b0, 0, 10);
        press(1'b1, 1'b0, 8, 8);

        // Reset mid-CHECK with next held: press discarded, full debounce after release.
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, 1'b0);
        do_reset();
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            tick(1'b1, 1'b0, 1'b0);
            if (cyc == 1) chk("rst_release_no_pulse", int'(sel_chg), 0);
            if (cyc == 6) chk("rst_pre_s", int'(s), 0);
            if (cyc == 7) begin
                chk("rst_step_s", int'(s), 1);
                chk("rst_step_pulse", int'(sel_chg), 1);
            end
        end
        chk("rst_one_pulse", pulses, 1);
        press(1'b0, 1'b0, 0, 10);

`ifdef MUX_SEL_SEQ_AUTOSCAN_EN
        // Auto-scan from edge 20: steps at 28, 36, 44; button presses ignored.
        @(negedge clk);
        do_reset();
        for (int i = 1; i <= 19; i++) tick(1'b0, 1'b0, 1'b0);
        while (cyc < 46) begin
            tick(((cyc / 6) % 2) == 1, 1'b0, 1'b1);
            if (cyc == 27) chk("scan_pre_s", int'(s), 0);
            if (cyc == 28) chk("scan_step1", int'(s), 1);
            if (cyc == 36) chk("scan_step2", int'(s), 2);
            if (cyc == 44) chk("scan_step3", int'(s), 3);
            if (cyc == 45) chk("scan_hold", int'(s), 3);
        end
        press(1'b0, 1'b0, 0, 10);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
